// File: rtl/jbus_sequencer.sv
// Round-robin sequencer for the shared 8-bit internal bus: grant, enable, set, hold, done.
// Define JBUS_SEQUENCER_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module jbus_sequencer #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [N-1:0]          breq,
  input  logic [N*AW-1:0]       bsrc,
  input  logic [N*AW-1:0]       bdst,
  input  logic [N-1:0]          bbus1,
  output logic [N-1:0]          bgnt,
  output logic [N-1:0]          bdone,
  output logic [(1<<AW)-1:0]    bena,
  output logic [(1<<AW)-1:0]    bset,
  output logic                  wbit1,
  output logic                  wbusy
);

  localparam int R  = 1 << AW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ENA, S_SET, S_HOLD, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   win_q, win_d, pick;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic            b1_q, b1_d;

  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic [R-1:0]    ena_q, ena_d;
  logic [R-1:0]    set_q, set_d;
  logic            bit1_q, bit1_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    win_oh;
  logic [R-1:0]    src_oh;
  logic [R-1:0]    dst_oh;

`ifdef JBUS_SEQUENCER_FIXED_PRIO_EN
  always_comb begin
    pick = '0;
    for (int k = N - 1; k >= 0; k--)
      if (breq[k]) pick = IW'(k);
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;
  int            idx;

  // Scan downward so the nearest requester after the pointer wins last.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (breq[idx[IW-1:0]]) pick = idx[IW-1:0];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_DONE) ptr_d = win_q;
  end

  always_ff @(posedge wclk) begin
    if (wrst) ptr_q <= IW'(N - 1);
    else      ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    src_d   = src_q;
    dst_d   = dst_q;
    b1_d    = b1_q;
    unique case (state_q)
      S_IDLE: begin
        if (|breq) begin
          state_d = S_GRANT;
          win_d   = pick;
          for (int i = 0; i < N; i++) begin
            if (IW'(i) == pick) begin
              src_d = bsrc[i*AW +: AW];
              dst_d = bdst[i*AW +: AW];
              b1_d  = bbus1[i];
            end
          end
        end
      end
      S_GRANT: state_d = S_ENA;
      S_ENA:   state_d = S_SET;
      S_SET:   state_d = S_HOLD;
      S_HOLD:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    win_oh = N'(1) << win_d;
    src_oh = R'(1) << src_d;
    dst_oh = R'(1) << dst_d;
    gnt_d  = '0;
    done_d = '0;
    ena_d  = '0;
    set_d  = '0;
    bit1_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_GRANT: gnt_d = win_oh;
      S_ENA, S_HOLD: begin
        gnt_d  = win_oh;
        ena_d  = src_oh;
        bit1_d = b1_d;
      end
      S_SET: begin
        gnt_d  = win_oh;
        ena_d  = src_oh;
        set_d  = dst_oh;
        bit1_d = b1_d;
      end
      S_DONE: begin
        gnt_d  = win_oh;
        done_d = win_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      b1_q    <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      ena_q   <= '0;
      set_q   <= '0;
      bit1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      b1_q    <= b1_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ena_q   <= ena_d;
      set_q   <= set_d;
      bit1_q  <= bit1_d;
      busy_q  <= busy_d;
    end
  end

  assign bgnt  = gnt_q;
  assign bdone = done_q;
  assign bena  = ena_q;
  assign bset  = set_q;
  assign wbit1 = bit1_q;
  assign wbusy = busy_q;

endmodule
